// File: rtl/order_pkg.sv
// order_pkg: shared encodings, ASCII codes, default widths and message length for the order decoder
package order_pkg;
  typedef enum logic [1:0] {MT_ADD = 2'd0, MT_CANCEL = 2'd1, MT_EXEC = 2'd2} msg_type_e;
  typedef enum logic [1:0] {IDLE, COLLECT, EMIT, DISCARD} dec_state_e;
  localparam logic [7:0] ASC_ADD    = 8'h41;
  localparam logic [7:0] ASC_CANCEL = 8'h58;
  localparam logic [7:0] ASC_EXEC   = 8'h45;
  localparam logic [7:0] ASC_BUY    = 8'h42;
  localparam logic [7:0] ASC_SELL   = 8'h53;
  localparam int ID_W_DEF    = 32;
  localparam int PRICE_W_DEF = 32;
  localparam int QTY_W_DEF   = 16;
  function automatic int msg_len(input int id_w, input int price_w, input int qty_w);
    return 2 + id_w / 8 + price_w / 8 + qty_w / 8;
  endfunction
endpackage

// File: rtl/be_field_shift.sv
// be_field_shift: big-endian byte shift register with a capture register for the finished field
//   clk, rst (async active-low) | shift: take din as next LSB byte | load: capture field into q
//   din: payload byte | q: captured field, held between loads
module be_field_shift #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift,
  input  logic         load,
  input  logic [7:0]   din,
  output logic [W-1:0] q
);
  logic [W-1:0] sh, nxt;
  if (W > 8) begin : g_wide
    assign nxt = {sh[W-9:0], din};
  end else begin : g_byte
    assign nxt = din;
  end
  // A load coinciding with a shift captures the field including this cycle's byte
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sh <= '0;
      q  <= '0;
    end else begin
      if (shift) sh <= nxt;
      if (load) q <= shift ? nxt : sh;
    end
endmodule

// File: rtl/order_msg_decoder.sv
// order_msg_decoder: assembles big-endian order messages from a payload byte stream
//   clk, rst (async active-low) | payload_data/payload_valid: byte stream | packet_done: end of payload
//   msg_valid + msg_type/msg_side/msg_order_id/msg_price/msg_qty: decoded record strobe
//   msg_err: dropped-message strobe
//   MSG_STATS_EN: adds stat_msgs/stat_errs saturating counters of the two strobes
module order_msg_decoder
  import order_pkg::*;
#(
  parameter int ID_W    = ID_W_DEF,
  parameter int PRICE_W = PRICE_W_DEF,
  parameter int QTY_W   = QTY_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         payload_data,
  input  logic               payload_valid,
  input  logic               packet_done,
  output logic               msg_valid,
  output logic [1:0]         msg_type,
  output logic               msg_side,
  output logic [ID_W-1:0]    msg_order_id,
  output logic [PRICE_W-1:0] msg_price,
  output logic [QTY_W-1:0]   msg_qty,
  output logic               msg_err
`ifdef MSG_STATS_EN
  ,
  output logic [31:0]        stat_msgs,
  output logic [15:0]        stat_errs
`endif
);
  localparam int MSG_LEN = msg_len(ID_W, PRICE_W, QTY_W);
  localparam int CW = $clog2(MSG_LEN);
  localparam logic [CW-1:0] ID_END    = CW'(ID_W / 8);
  localparam logic [CW-1:0] SIDE_OFF  = CW'(ID_W / 8 + 1);
  localparam logic [CW-1:0] PRICE_END = CW'(ID_W / 8 + 1 + PRICE_W / 8);
  localparam logic [CW-1:0] LAST      = CW'(MSG_LEN - 1);
  dec_state_e state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  msg_type_e type_q, type_code;
  logic side_q, err_nxt, type_ok, side_ok, type_ld, side_ld, last_ld, coll_byte;
  assign type_ok   = payload_data inside {ASC_ADD, ASC_CANCEL, ASC_EXEC};
  assign type_code = payload_data == ASC_ADD ? MT_ADD : payload_data == ASC_CANCEL ? MT_CANCEL : MT_EXEC;
  assign side_ok   = payload_data == ASC_BUY || payload_data == ASC_SELL;
  assign coll_byte = state == COLLECT && payload_valid;
  assign msg_valid = state == EMIT;
  // IDLE and EMIT share the type-byte handling so back-to-back messages need no dead cycle;
  // an error coinciding with packet_done returns straight to IDLE since the packet is over.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    err_nxt   = 1'b0;
    type_ld   = 1'b0;
    side_ld   = 1'b0;
    last_ld   = 1'b0;
    if (state == COLLECT) begin
      if (payload_valid && count == SIDE_OFF && !side_ok) begin
        err_nxt   = 1'b1;
        state_nxt = packet_done ? IDLE : DISCARD;
      end else if (payload_valid && count == LAST) begin
        last_ld   = 1'b1;
        state_nxt = EMIT;
      end else begin
        side_ld   = payload_valid && count == SIDE_OFF;
        count_nxt = payload_valid ? count + CW'(1) : count;
        err_nxt   = packet_done;
        state_nxt = packet_done ? IDLE : COLLECT;
      end
    end else if (state == DISCARD) begin
      state_nxt = packet_done ? IDLE : DISCARD;
    end else begin
      state_nxt = IDLE;
      if (payload_valid) begin
        type_ld   = type_ok;
        count_nxt = CW'(1);
        err_nxt   = !type_ok || packet_done;
        state_nxt = packet_done ? IDLE : type_ok ? COLLECT : DISCARD;
      end
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= IDLE;
      count    <= '0;
      type_q   <= MT_ADD;
      side_q   <= 1'b0;
      msg_type <= '0;
      msg_side <= 1'b0;
      msg_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      msg_err <= err_nxt;
      if (type_ld) type_q <= type_code;
      if (side_ld) side_q <= payload_data == ASC_SELL;
      if (last_ld) begin
        msg_type <= type_q;
        msg_side <= side_q;
      end
    end
  be_field_shift #(.W(ID_W)) u_id (
    .clk(clk), .rst(rst), .shift(coll_byte && count <= ID_END), .load(last_ld),
    .din(payload_data), .q(msg_order_id)
  );
  be_field_shift #(.W(PRICE_W)) u_price (
    .clk(clk), .rst(rst), .shift(coll_byte && count > SIDE_OFF && count <= PRICE_END), .load(last_ld),
    .din(payload_data), .q(msg_price)
  );
  be_field_shift #(.W(QTY_W)) u_qty (
    .clk(clk), .rst(rst), .shift(coll_byte && count > PRICE_END), .load(last_ld),
    .din(payload_data), .q(msg_qty)
  );
`ifdef MSG_STATS_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stat_msgs <= '0;
      stat_errs <= '0;
    end else begin
      if (msg_valid && !(&stat_msgs)) stat_msgs <= stat_msgs + 32'd1;
      if (msg_err && !(&stat_errs)) stat_errs <= stat_errs + 16'd1;
    end
`endif
endmodule

// File: tb/tb_order_msg_decoder.sv
// tb_order_msg_decoder: directed and random packets checked cycle by cycle against a message-level model
module tb_order_msg_decoder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] payload_data = 8'h00;
  logic payload_valid = 1'b0;
  logic packet_done = 1'b0;
  logic msg_valid, msg_side, msg_err;
  logic [1:0] msg_type;
  logic [31:0] msg_order_id, msg_price;
  logic [15:0] msg_qty;
`ifdef MSG_STATS_EN
  logic [31:0] stat_msgs;
  logic [15:0] stat_errs;
`endif
  int checks = 0;
  int failures = 0;
  logic [7:0] pkt[$];
  logic [7:0] m1[$];
  int gap[$];
  bit pd_last;

  always #5 clk = ~clk;

  order_msg_decoder dut (
    .clk(clk), .rst(rst), .payload_data(payload_data), .payload_valid(payload_valid),
    .packet_done(packet_done), .msg_valid(msg_valid), .msg_type(msg_type), .msg_side(msg_side),
    .msg_order_id(msg_order_id), .msg_price(msg_price), .msg_qty(msg_qty), .msg_err(msg_err)
`ifdef MSG_STATS_EN
    , .stat_msgs(stat_msgs), .stat_errs(stat_errs)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit type_ok(input logic [7:0] b);
    return b == 8'h41 || b == 8'h58 || b == 8'h45;
  endfunction

  function automatic logic [1:0] type_code(input logic [7:0] b);
    return b == 8'h41 ? 2'd0 : b == 8'h58 ? 2'd1 : 2'd2;
  endfunction

  function automatic bit side_ok(input logic [7:0] b);
    return b == 8'h42 || b == 8'h53;
  endfunction

  function automatic logic [31:0] be_val(input int s, input int w);
    logic [31:0] v = 0;
    for (int k = 0; k < w; k++) v = v * 256 + 32'(pkt[s+k]);
    return v;
  endfunction

  task automatic push_msg(input logic [7:0] t, input logic [7:0] s, input logic [31:0] id,
                          input logic [31:0] pr, input logic [15:0] q);
    pkt.push_back(t);
    for (int k = 3; k >= 0; k--) pkt.push_back(id[8*k+:8]);
    pkt.push_back(s);
    for (int k = 3; k >= 0; k--) pkt.push_back(pr[8*k+:8]);
    for (int k = 1; k >= 0; k--) pkt.push_back(q[8*k+:8]);
  endtask

  task automatic flat(input bit pd);
    gap.delete();
    foreach (pkt[i]) gap.push_back(0);
    pd_last = pd;
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic pd, input int e,
                      input logic [1:0] t, input logic s, input logic [31:0] id,
                      input logic [31:0] pr, input logic [15:0] q);
    payload_valid = v;
    payload_data  = d;
    packet_done   = pd;
    @(posedge clk);
    #1;
    check("msg_valid", 64'(msg_valid), 64'(e == 1));
    check("msg_err", 64'(msg_err), 64'(e == 2));
    if (e == 1) begin
      check("msg_type", 64'(msg_type), 64'(t));
      check("msg_side", 64'(msg_side), 64'(s));
      check("msg_order_id", 64'(msg_order_id), 64'(id));
      check("msg_price", 64'(msg_price), 64'(pr));
      check("msg_qty", 64'(msg_qty), 64'(q));
    end
  endtask

  task automatic idle_step();
    step(1'b0, 8'($urandom), 1'b0, 0, 2'd0, 1'b0, 32'd0, 32'd0, 16'd0);
  endtask

  // Walk the packet message by message and record, per byte, which strobe it must produce.
  task automatic run_packet();
    int n, p, k, e;
    int ev[64];
    logic [1:0] et[64];
    logic es[64];
    logic [31:0] eid[64], epr[64];
    logic [15:0] eq[64];
    bit pd_err, stop;
    n = pkt.size();
    p = 0;
    pd_err = 0;
    stop = 0;
    for (int i = 0; i < 64; i++) begin
      ev[i] = 0; et[i] = 0; es[i] = 0; eid[i] = 0; epr[i] = 0; eq[i] = 0;
    end
    while (p < n && !stop) begin
      if (!type_ok(pkt[p])) begin
        ev[p] = 2;
        stop = 1;
      end else if (p + 5 < n && !side_ok(pkt[p+5])) begin
        ev[p+5] = 2;
        stop = 1;
      end else if (p + 12 > n) begin
        pd_err = 1;
        stop = 1;
      end else begin
        k = p + 11;
        ev[k]  = 1;
        et[k]  = type_code(pkt[p]);
        es[k]  = pkt[p+5] == 8'h53;
        eid[k] = be_val(p + 1, 4);
        epr[k] = be_val(p + 6, 4);
        eq[k]  = 16'(be_val(p + 10, 2));
        p += 12;
      end
    end
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap[i]; g++) idle_step();
      e = ev[i];
      if (i == n - 1 && pd_last && e == 0 && pd_err) e = 2;
      step(1'b1, pkt[i], i == n - 1 && pd_last, e, et[i], es[i], eid[i], epr[i], eq[i]);
    end
    if (!pd_last) step(1'b0, 8'($urandom), 1'b1, pd_err ? 2 : 0, 2'd0, 1'b0, 32'd0, 32'd0, 16'd0);
    repeat (2) idle_step();
  endtask

  task automatic make_random();
    int nm, mode, idx, cut;
    logic [7:0] b;
    logic [7:0] tc[3];
    tc[0] = 8'h41; tc[1] = 8'h58; tc[2] = 8'h45;
    pkt.delete();
    nm = $urandom_range(1, 3);
    mode = $urandom_range(0, 4);
    for (int m = 0; m < nm; m++)
      push_msg(tc[$urandom_range(0, 2)], $urandom_range(0, 1) ? 8'h53 : 8'h42,
               $urandom, $urandom, 16'($urandom));
    idx = 12 * $urandom_range(0, nm - 1);
    if (mode == 2) begin
      do b = 8'($urandom); while (type_ok(b));
      pkt[idx] = b;
    end else if (mode == 3) begin
      do b = 8'($urandom); while (side_ok(b));
      pkt[idx+5] = b;
    end else if (mode == 4) begin
      cut = $urandom_range(1, pkt.size() - 1);
      while (pkt.size() > cut) void'(pkt.pop_back());
    end
    gap.delete();
    foreach (pkt[i]) gap.push_back($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
    pd_last = 1'($urandom_range(0, 1));
  endtask

  initial begin
    m1 = '{8'h41, 8'h00, 8'h00, 8'h12, 8'h34, 8'h42, 8'h00, 8'h01, 8'h86, 8'hA0, 8'h00, 8'h64};
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(msg_valid), 64'd0);
    check("rst_err", 64'(msg_err), 64'd0);
    check("rst_type", 64'(msg_type), 64'd0);
    check("rst_side", 64'(msg_side), 64'd0);
    check("rst_id", 64'(msg_order_id), 64'd0);
    check("rst_price", 64'(msg_price), 64'd0);
    check("rst_qty", 64'(msg_qty), 64'd0);
    rst = 1'b1;
    idle_step();
    pkt = m1;
    flat(0);
    run_packet();
    check("hold_type", 64'(msg_type), 64'd0);
    check("hold_side", 64'(msg_side), 64'd0);
    check("hold_id", 64'(msg_order_id), 64'h1234);
    check("hold_price", 64'(msg_price), 64'd100000);
    check("hold_qty", 64'(msg_qty), 64'd100);
    pkt.delete();
    push_msg(8'h58, 8'h42, 32'hDEADBEEF, 32'd5000, 16'd7);
    push_msg(8'h45, 8'h53, 32'h0BADF00D, 32'd12345, 16'd250);
    flat(1);
    run_packet();
    check("hold_side_sell", 64'(msg_side), 64'd1);
    pkt = '{8'h5A};
    repeat (11) pkt.push_back(8'($urandom));
    flat(0);
    run_packet();
    pkt = m1;
    flat(0);
    run_packet();
    pkt = m1[0:6];
    flat(0);
    run_packet();
    pkt = m1;
    flat(1);
    run_packet();
    pkt = m1;
    flat(0);
    gap[8] = 3;
    run_packet();
    pkt.delete();
    push_msg(8'h45, 8'h53, 32'hCAFEF00D, 32'd777, 16'd9);
    for (int i = 0; i < 6; i++) step(1'b1, pkt[i], 1'b0, 0, 2'd0, 1'b0, 32'd0, 32'd0, 16'd0);
    rst = 1'b0;
    step(1'b1, pkt[6], 1'b0, 0, 2'd0, 1'b0, 32'd0, 32'd0, 16'd0);
    check("rst_mid_id", 64'(msg_order_id), 64'd0);
    check("rst_mid_price", 64'(msg_price), 64'd0);
    rst = 1'b1;
    idle_step();
    pkt = m1;
    flat(0);
    run_packet();
    for (int r = 0; r < 40; r++) begin
      make_random();
      run_packet();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
